// File: rtl/spi_xfer_counter_pkg.sv
// ---------------------------------------------------------------------------
// spi_io_pkg
// Shared types and constants for the SPI flash transfer counter slice.
//   xfer_state_t   : sequencing FSM states (IDLE, RUN, DONE)
//   DEFAULT_*      : default word geometry and length width
//   bit_w_fits()   : elaboration-time check that a bit counter of width
//                    bit_w can hold the values 0 .. bits_per_word-1
// ---------------------------------------------------------------------------
package spi_io_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } xfer_state_t;

   localparam int DEFAULT_BITS_PER_WORD = 8;
   localparam int DEFAULT_BIT_W         = 3;
   localparam int DEFAULT_LEN_W         = 16;

   // True when 2**bit_w >= bits_per_word, so the bit counter can hold the
   // last bit index of a word.
   function automatic bit bit_w_fits(input int bit_w, input int bits_per_word);
      return (longint'(1) << bit_w) >= longint'(bits_per_word);
   endfunction

endpackage

// File: rtl/spi_xfer_counter_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_counter_if
// Handshake and progress bundle between the SPI flash controller (master)
// and the transfer counter (slave).
//   start     : begin a transfer (controller -> counter)
//   len       : transfer length in words, LEN_W bits
//   bit_tick  : one serial bit shifted this cycle
//   abort     : synchronous cancel
//   busy      : counter is in RUN
//   bit_cnt   : bits completed in the current word, BIT_W bits
//   word_cnt  : words completed, LEN_W bits
//   word_done : one-cycle pulse per completed word
//   xfer_done : one-cycle pulse on transfer completion
// ---------------------------------------------------------------------------
interface spi_xfer_counter_if #(
   parameter int BIT_W = 3,
   parameter int LEN_W = 16
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             bit_tick;
   logic             abort;
   logic             busy;
   logic [BIT_W-1:0] bit_cnt;
   logic [LEN_W-1:0] word_cnt;
   logic             word_done;
   logic             xfer_done;

   modport master (
      output start, len, bit_tick, abort,
      input  busy, bit_cnt, word_cnt, word_done, xfer_done
   );

   modport slave (
      input  start, len, bit_tick, abort,
      output busy, bit_cnt, word_cnt, word_done, xfer_done
   );
endinterface

// File: rtl/spi_xfer_counter_mod_counter.sv
// ---------------------------------------------------------------------------
// spi_mod_counter
// Modulo-MOD up counter with synchronous clear and a registered wrap strobe.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   inc   : advance the count by one this cycle
//   clr   : force the count to zero (wins over inc, suppresses wrap)
//   count : current count, W bits, range 0 .. MOD-1
//   wrap  : one-cycle pulse in the cycle after the count wrapped MOD-1 -> 0
// ---------------------------------------------------------------------------
module spi_mod_counter #(
   parameter int MOD = 8,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         wrap
);

   // Count register and wrap strobe; the strobe is registered so it lines up
   // with the count having already returned to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            count <= '0;
         end else if (inc) begin
            if (count == W'(MOD - 1)) begin
               count <= '0;
               wrap  <= 1'b1;
            end else begin
               count <= count + W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/spi_xfer_counter.sv
// ---------------------------------------------------------------------------
// spi_xfer_counter
// Two-level transfer counter for the SPI flash datapath: bit ticks are
// counted into words, words are counted against a captured length.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_xfer_counter_if.slave (start/len/bit_tick/abort in,
//          busy/bit_cnt/word_cnt/word_done/xfer_done out)
// Build option: SPI_XFER_CNT_STREAM_EN -- when defined, a start with len==0
// runs an unbounded stream (word_cnt wraps, no xfer_done); when undefined a
// zero-length start completes immediately through DONE.
// ---------------------------------------------------------------------------
module spi_xfer_counter
   import spi_io_pkg::*;
#(
   parameter int BITS_PER_WORD = DEFAULT_BITS_PER_WORD,
   parameter int BIT_W         = DEFAULT_BIT_W,
   parameter int LEN_W         = DEFAULT_LEN_W
) (
   input logic                clk,
   input logic                rst,
   spi_xfer_counter_if.slave  bus
);

   if (BITS_PER_WORD < 2 || !bit_w_fits(BIT_W, BITS_PER_WORD)) begin : g_param_check
      $error("spi_xfer_counter: BIT_W too narrow for BITS_PER_WORD or BITS_PER_WORD < 2");
   end

   xfer_state_t      state_q;
   logic             busy_q;
   logic             xfer_done_q;
   logic [LEN_W-1:0] word_cnt_q;
   logic [LEN_W-1:0] len_q;
   logic [BIT_W-1:0] bit_cnt;
   logic             word_done;
   logic             stream_q;

   logic accept_start;
   logic run_tick;
   logic last_bit;
   logic last_word;
   logic bit_clr;

   // Abort outranks start, start outranks bit_tick; these qualifiers encode
   // that ordering once so the FSM and bit counter agree.
   assign accept_start = (state_q == IDLE) && bus.start && !bus.abort;
   assign run_tick     = (state_q == RUN) && bus.bit_tick && !bus.abort;
   assign last_bit     = (bit_cnt == BIT_W'(BITS_PER_WORD - 1));
   assign last_word    = (word_cnt_q == (len_q - LEN_W'(1))) && !stream_q;
   assign bit_clr      = bus.abort || accept_start;

   // Bit level: the wrap strobe doubles as word_done, so clearing on abort
   // also suppresses a word pulse on a coincident final tick.
   spi_mod_counter #(
      .MOD (BITS_PER_WORD),
      .W   (BIT_W)
   ) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (run_tick),
      .clr   (bit_clr),
      .count (bit_cnt),
      .wrap  (word_done)
   );

`ifdef SPI_XFER_CNT_STREAM_EN
   // Stream flag: set by a zero-length start, disables the length compare
   // until the transfer is aborted or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stream_q <= 1'b0;
      end else if (bus.abort) begin
         stream_q <= 1'b0;
      end else if (accept_start) begin
         stream_q <= (bus.len == '0);
      end
   end
`else
   assign stream_q = 1'b0;
`endif

   // Sequencing FSM with registered busy/xfer_done and the word counter.
   // xfer_done is raised on entry to DONE so it coincides with that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         xfer_done_q <= 1'b0;
         word_cnt_q  <= '0;
         len_q       <= '0;
      end else begin
         xfer_done_q <= 1'b0;
         if (bus.abort) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            word_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     len_q      <= bus.len;
                     word_cnt_q <= '0;
`ifdef SPI_XFER_CNT_STREAM_EN
                     state_q    <= RUN;
                     busy_q     <= 1'b1;
`else
                     if (bus.len != '0) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                     end else begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        xfer_done_q <= 1'b1;
                     end
`endif
                  end
               end
               RUN: begin
                  if (run_tick && last_bit) begin
                     word_cnt_q <= word_cnt_q + LEN_W'(1);
                     if (last_word) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        xfer_done_q <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.bit_cnt   = bit_cnt;
   assign bus.word_cnt  = word_cnt_q;
   assign bus.word_done = word_done;
   assign bus.xfer_done = xfer_done_q;

endmodule
